sram_like_resp: RTL and testbench

SRAM_LIKE_RESP -- requirements
Module: sram_like_resp

---
 rtl/sram_like_resp.sv | 155 +++++++++++++++
 tb/tb_sram_like_resp.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_resp.sv
// SRAM-like slave responder: in-order request queue feeding a 1-wait-state synchronous RAM.
// Define SRAM_LIKE_RESP_RAND_DELAY_EN to replace the fixed LAT delay with a per-access random 0..3 delay.
module sram_like_resp #(
  parameter int DEPTH = 2,
  parameter int LAT   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic        e_wr;
    logic [3:0]  e_strb;
    logic [29:0] e_addr;
    logic [31:0] e_data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

  entry_t          q_mem [DEPTH];
  entry_t          head;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            push, pop;

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic [3:0]      dly;
  logic            data_ok_q, mem_en_q;
  logic [3:0]      mem_we_q;
  logic [29:0]     mem_addr_q;
  logic [31:0]     mem_wdata_q;

  logic            unused_ok;
  assign unused_ok = ^{size, addr[1:0]};

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // No full-bypass: a pop in the same cycle does not free a slot for the push.
  assign addr_ok = req & ~reset & (count_q < CW'(DEPTH));
  assign push    = req & addr_ok;
  assign pop     = (state_q == ACCESS);
  assign head    = q_mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      q_mem[wr_ptr_q] <= '{e_wr: wr, e_strb: wstrb, e_addr: addr[31:2], e_data: wdata};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef SRAM_LIKE_RESP_RAND_DELAY_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 8'hA5;
    else       lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign dly = {2'b00, lfsr_q[1:0]};
`else
  assign dly = 4'(LAT);
`endif

  // RAM strobes are registered one cycle early so they are live exactly in the WAIT cycle with counter zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      data_ok_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      data_ok_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      case (state_q)
        IDLE: begin
          if (count_q != '0) begin
            cnt_q   <= dly;
            state_q <= WAIT;
            if (dly == 4'd0) begin
              mem_en_q    <= 1'b1;
              mem_addr_q  <= head.e_addr;
              mem_we_q    <= head.e_wr ? head.e_strb : 4'b0000;
              mem_wdata_q <= head.e_data;
            end
          end
        end
        WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              mem_en_q    <= 1'b1;
              mem_addr_q  <= head.e_addr;
              mem_we_q    <= head.e_wr ? head.e_strb : 4'b0000;
              mem_wdata_q <= head.e_data;
            end
          end else begin
            state_q   <= ACCESS;
            data_ok_q <= 1'b1;
          end
        end
        ACCESS:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_ok   = data_ok_q & ~reset;
  assign rdata     = (data_ok && !head.e_wr) ? mem_rdata : 32'h0;
  assign mem_en    = mem_en_q & ~reset;
  assign mem_we    = reset ? 4'b0000 : mem_we_q;
  assign mem_addr  = reset ? 30'h0 : mem_addr_q;
  assign mem_wdata = reset ? 32'h0 : mem_wdata_q;

endmodule

// File: tb/tb_sram_like_resp.sv
// Scoreboard bench for sram_like_resp: a word-level memory/timing model predicts each response.
module tb_sram_like_resp;
  localparam int DEPTH = 2;
  localparam int LAT   = 3;

  logic        clk = 1'b0;
  logic        reset, req, wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  typedef struct {
    int          due;
    logic [31:0] rd;
    logic [29:0] waddr;
    logic [3:0]  we;
  } exp_t;

  exp_t        sb[$];
  int          done_q[$];
  int          last_done = 0, rel_cyc = 0;
  int          checks = 0, errors = 0;
  int          cyc = 0;
  int          dok_cnt = 0, hs_cnt = 0;
  logic        tb_init = 1'b1;
  logic [31:0] ram [1024];
  logic [31:0] mdl [1024];

  sram_like_resp #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    if (i == 256) return 32'h12345678;
    if (i < 16) return 32'h0;
    return 32'(i) * 32'h9E3779B1;
  endfunction

  // Backing synchronous RAM: read data appears the cycle after mem_en.
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_word(i);
    end else if (mem_en) begin
      mem_rdata <= ram[mem_addr[9:0]];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] lfsr_at(input int n);
    logic [7:0] l;
    l = 8'hA5;
    for (int i = 0; i < n; i++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    return l;
  endfunction

  function automatic int outstanding(input int c);
    int n;
    n = done_q.size();
    foreach (done_q[k]) if (done_q[k] < c) n--;
    return n;
  endfunction

  // Reference model: apply the access to a word memory, and time it from the service rules.
  task automatic model_accept(input int a, input logic w, input logic [3:0] s,
                              input logic [31:0] ad, input logic [31:0] d);
    exp_t e;
    int   start, dl;
    logic [9:0] idx;
    idx = ad[11:2];
    e.rd = 32'h0;
    if (w) begin
      for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
    end else begin
      e.rd = mdl[idx];
    end
    start = (a + 1 > last_done + 1) ? a + 1 : last_done + 1;
`ifdef SRAM_LIKE_RESP_RAND_DELAY_EN
    dl = int'(lfsr_at(start - rel_cyc) & 8'h03);
`else
    dl = LAT;
`endif
    e.due   = start + 2 + dl;
    e.waddr = ad[31:2];
    e.we    = w ? s : 4'b0000;
    last_done = e.due;
    done_q.push_back(e.due);
    sb.push_back(e);
    hs_cnt++;
  endtask

  task automatic issue(input logic w, input logic [3:0] s, input logic [31:0] ad,
                       input logic [31:0] d, input logic hold);
    bit accepted;
    accepted = 0;
    req = 1'b1; wr = w; wstrb = s; addr = ad; wdata = d; size = 2'($urandom_range(0, 3));
    for (int t = 0; t < 50 && !accepted; t++) begin
      @(negedge clk);
      chk("addr_ok", {31'h0, addr_ok}, {31'h0, outstanding(cyc) < DEPTH});
      if (addr_ok) begin
        model_accept(cyc, w, s, ad, d);
        accepted = 1;
      end
      @(posedge clk); #1;
    end
    if (!accepted) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no addr_ok expected acceptance of %h", ad);
    end
    if (!hold) req = 1'b0;
  endtask

  task automatic wait_drain();
    bit drained;
    drained = 0;
    for (int t = 0; t < 300 && !drained; t++) begin
      @(negedge clk);
      if (sb.size() == 0) drained = 1;
    end
    if (!drained) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  // Monitor: pops and compares whenever the DUT presents a RAM access or a response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_en) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_en_unexpected: got mem_en=1 expected 0 (cycle %0d)", cyc);
        end else begin
          chk("mem_en_cycle", cyc + 1, sb[0].due);
          chk("mem_addr", {2'b00, mem_addr}, {2'b00, sb[0].waddr});
          chk("mem_we", {28'h0, mem_we}, {28'h0, sb[0].we});
        end
      end
      if (data_ok) begin
        dok_cnt++;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL data_ok_unexpected: got data_ok=1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("resp_cycle", cyc, e.due);
          chk("resp_rdata", rdata, e.rd);
          $display("resp cycle %0d word %h rdata %h", cyc, e.waddr, rdata);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        checks++; errors++;
        $display("FAIL resp_missing: got no data_ok expected one at cycle %0d", e.due);
      end
    end
  end

  initial begin
    int hs0, dk0;
    for (int i = 0; i < 1024; i++) mdl[i] = init_word(i);
    reset = 1'b1; req = 1'b1; wr = 1'b0; size = 2'b00; wstrb = 4'h0; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_addr_ok", {31'h0, addr_ok}, 32'h0);
    chk("reset_data_ok", {31'h0, data_ok}, 32'h0);
    chk("reset_mem_en", {31'h0, mem_en}, 32'h0);
    chk("reset_mem_we", {28'h0, mem_we}, 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; tb_init = 1'b0; req = 1'b0;
    rel_cyc = cyc; last_done = cyc - 1;

    // Single read of the preloaded word.
    issue(1'b0, 4'h0, 32'h1c000400, 32'h0, 1'b0);
    wait_drain();

    // Three back-to-back reads with req held; the third waits for a free slot.
    issue(1'b0, 4'h0, 32'h1c000404, 32'h0, 1'b1);
    issue(1'b0, 4'h0, 32'h1c000408, 32'h0, 1'b1);
    issue(1'b0, 4'h0, 32'h1c00040c, 32'h0, 1'b0);
    wait_drain();

    // Partial write then read-back, plus a misaligned read of the same word.
    issue(1'b1, 4'b0011, 32'h00000008, 32'hAABBCCDD, 1'b0);
    issue(1'b0, 4'h0, 32'h00000008, 32'h0, 1'b0);
    issue(1'b0, 4'h0, 32'h0000000b, 32'h0, 1'b0);
    wait_drain();

    // Reset one cycle after accepting a read: the read must vanish.
    issue(1'b0, 4'h0, 32'h1c000400, 32'h0, 1'b0);
    reset = 1'b1; req = 1'b1;
    sb.delete(); done_q.delete();
    @(negedge clk);
    chk("midreset_addr_ok", {31'h0, addr_ok}, 32'h0);
    chk("midreset_data_ok", {31'h0, data_ok}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; req = 1'b0;
    rel_cyc = cyc; last_done = cyc - 1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk("post_reset_quiet", {31'h0, data_ok}, 32'h0);
    end
    @(posedge clk); #1;

    // Random traffic; every handshake must get exactly one data_ok.
    hs0 = hs_cnt; dk0 = dok_cnt;
    for (int n = 0; n < 100; n++) begin
      logic        w;
      logic [31:0] ad;
      w  = 1'($urandom_range(0, 1));
      ad = {20'h1c000, 2'b00, 6'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      ad[11:2] = 10'($urandom_range(0, 15));
      issue(w, 4'($urandom_range(0, 15)), ad, $urandom, 1'($urandom_range(0, 1)));
      if (!req) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    req = 1'b0;
    wait_drain();
    chk("data_ok_count", dok_cnt - dk0, hs_cnt - hs0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
